seq_divider: RTL
================

Name: seq_divider

Overview:
Parametrised sequential unsigned restoring divider, WIDTH bits.
- Successor to the fixed 8-bit bitslice divider array.
- Produces one quotient bit per clock, with Start/Done handshake and divide-by-zero detection.
- Sits between the operand registers and the result bus of the arithmetic unit.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits (legal range 2..32)

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request a division; sampled only when not Busy
Dividend  input  WIDTH  dividend, captured on accepted Start
Divisor  input  WIDTH  divisor, captured on accepted Start
Busy  output  1  high while a division is in progress (RUN state)
Done  output  1  one-cycle pulse; results valid on this cycle and held afterwards
Quotient  output  WIDTH  quotient result
Remainder  output  WIDTH  remainder result
Overflow  output  1  divisor was zero; held with results

Behaviour:
- Reset (synchronous, active-high) has priority over everything.
  - Resets to IDLE with Busy=0, Done=0, Quotient=0, Remainder=0, Overflow=0, cycle count=0.
  - Reset mid-operation aborts the division; no Done is produced.
- FSM states: IDLE, RUN, DONE.
- Start is accepted in IDLE or DONE and ignored in RUN.
  - Acceptance in DONE allows back-to-back operations with no idle cycle.
- On accept with Divisor != 0:
  - A := 0 (WIDTH+1 bits); Q := Dividend; M := Divisor; count := WIDTH.
  - Overflow := 0; next state RUN.
- On accept with Divisor == 0:
  - Next state DONE.
  - Quotient := all-ones, Remainder := Dividend, Overflow := 1.
  - Done appears on the cycle after Start.
- RUN, each cycle:
  - Shift {A,Q} left one bit.
  - Trial difference D := A - {0,M}, computed in WIDTH+1 bits.
  - If D is non-negative (no borrow): A := D and Q[0] := 1; otherwise A is unchanged and Q[0] := 0.
  - count decrements; when count reaches 1, the current step is the last one and the next state is DONE.
- DONE:
  - Done=1 for exactly one cycle; Quotient := Q, Remainder := A[WIDTH-1:0].
  - Next state is IDLE, or RUN if Start is accepted that cycle.
- Latency: Start accepted at cycle 0 gives Done at cycle WIDTH+1.
- Busy is high on cycles 1..WIDTH and low in IDLE and DONE.
- Quotient, Remainder and Overflow hold their values until the next result is produced.
  - Inputs may change freely after Start is accepted.
- Start held continuously: a new operation is accepted in every DONE cycle.
- Width rule: all arithmetic is unsigned.
  - The remainder is always < Divisor.
  - Quotient*Divisor + Remainder == Dividend for Divisor != 0.

Optional Feature:
Macro: SEQ_DIVIDER_SCAN_EN.
- Defined: adds ports Test (input 1), SDI (input 1) and SDO (output 1).
  - While Test=1, the FSM and count are frozen.
  - A, Q and M form a serial chain that shifts one bit per Clock: SDI -> M[0] ... M[WIDTH-1] -> Q[0] ... Q[WIDTH-1] -> A[0] ... A[WIDTH] -> SDO.
  - Reset still has priority over the scan shift.
  - With Test=0, behaviour is identical to the build without the macro.
- Undefined: no scan ports and no scan logic.

Decomposition:
- Package seq_divider_pkg holds:
  - state enum type div_state_t (IDLE, RUN, DONE);
  - localparam DEFAULT_WIDTH = 8;
  - count width function clog2(WIDTH+1).
- One sub-module, div_trial_sub, is natural:
  - combinational WIDTH+1-bit subtractor;
  - outputs the difference and nBorrowOut;
  - the parametrised counterpart of the per-bit slice.
- The FSM, count and A/Q/M registers live in seq_divider.

Test Plan:
- WIDTH=8, Dividend=100, Divisor=7, Start for one cycle -> Busy high for 8 cycles; Done at cycle 9 with Quotient=14, Remainder=2, Overflow=0.
- Dividend=0x55, Divisor=0 -> Done at cycle 1; Quotient=0xFF, Remainder=0x55, Overflow=1; Busy never high.
- Boundaries: 255/1 -> Q=255, R=0; 3/200 -> Q=0, R=3; 255/255 -> Q=1, R=0.
- Start pulsed again at cycle 4 of a 100/7 run with 9/3 on inputs -> ignored; result 14 r 2.
  - Start held continuously with new operands -> back-to-back Done every 9 cycles.
- Reset asserted at cycle 5 of a run -> next cycle IDLE, all outputs 0, no Done.
  - A subsequent 200/9 run -> Q=22, R=2.
- WIDTH=16: 50000/123 -> Q=406, R=62 at cycle 17.
  - With SEQ_DIVIDER_SCAN_EN, scanning 3*WIDTH+1 known bits in with Test=1 -> the same pattern emerges on SDO, and the FSM state is unchanged.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The step counter must be able to hold the value WIDTH itself.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational N-bit ripple-borrow subtractor built from per-bit slices.
module div_trial_sub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         n_borrow_out
);

    logic [N:0] borrow;

    assign borrow[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign diff[gi]       = a[gi] ^ b[gi] ^ borrow[gi];
            assign borrow[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow[gi]);
        end
    endgenerate

    assign n_borrow_out = ~borrow[N];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, Start/Done handshake.
// Optional scan chain over A/Q/M enabled by defining SEQ_DIVIDER_SCAN_EN.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
`ifdef SEQ_DIVIDER_SCAN_EN
    input  logic             Test,
    input  logic             SDI,
    output logic             SDO,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Overflow
);

    localparam int CW = count_width(WIDTH);

    div_state_t       state_reg;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             overflow_reg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial_diff;
    logic             n_borrow;
    logic             take;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;

    assign shifted = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    div_trial_sub #(.N(WIDTH + 1)) u_trial (
        .a            (shifted),
        .b            ({1'b0, m_reg}),
        .diff         (trial_diff),
        .n_borrow_out (n_borrow)
    );

    // A bit shifted out of A means the partial remainder certainly exceeds M.
    assign take   = n_borrow | a_reg[WIDTH];
    assign a_next = take ? trial_diff : shifted;
    assign q_next = {q_reg[WIDTH-2:0], take};
    assign accept = Start && (state_reg != RUN);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            q_reg         <= '0;
            m_reg         <= '0;
            count_reg     <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            overflow_reg  <= 1'b0;
        end
`ifdef SEQ_DIVIDER_SCAN_EN
        else if (Test) begin
            m_reg <= {m_reg[WIDTH-2:0], SDI};
            q_reg <= {q_reg[WIDTH-2:0], m_reg[WIDTH-1]};
            a_reg <= {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        end
`endif
        else begin
            case (state_reg)
                RUN: begin
                    a_reg     <= a_next;
                    q_reg     <= q_next;
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == CW'(1)) begin
                        state_reg     <= DONE;
                        quotient_reg  <= q_next;
                        remainder_reg <= a_next[WIDTH-1:0];
                    end
                end
                default: begin
                    if (accept) begin
                        if (Divisor != '0) begin
                            a_reg        <= '0;
                            q_reg        <= Dividend;
                            m_reg        <= Divisor;
                            count_reg    <= CW'(WIDTH);
                            overflow_reg <= 1'b0;
                            state_reg    <= RUN;
                        end else begin
                            quotient_reg  <= '1;
                            remainder_reg <= Dividend;
                            overflow_reg  <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign Busy      = (state_reg == RUN);
    assign Done      = (state_reg == DONE);
    assign Quotient  = quotient_reg;
    assign Remainder = remainder_reg;
    assign Overflow  = overflow_reg;
`ifdef SEQ_DIVIDER_SCAN_EN
    assign SDO       = a_reg[WIDTH];
`endif

endmodule
